// File: rtl/dcfifo_write_control_if.sv
// dcfifo write-port bundle: request, data and the write-side full flag.
// master drives the FIFO (sequencer side); slave is the FIFO side.
interface dcfifo_write_control_if;
    logic        wrreq_o;
    logic [31:0] data_o;
    logic        wrfull_i;

    modport master (
        output wrreq_o,
        output data_o,
        input  wrfull_i
    );

    modport slave (
        input  wrreq_o,
        input  data_o,
        output wrfull_i
    );
endinterface

// File: rtl/dcfifo_write_control.sv
// Write-side burst sequencer for the dual-clock FIFO example: pushes BURST_LEN pattern words, stalls on full.
// Define DCFIFO_WRCTL_LFSR_EN for a 32-bit Fibonacci LFSR pattern; the default is an incrementing counter.
module dcfifo_write_control #(
    parameter int unsigned BURST_LEN = 256,
    parameter logic [31:0] DATA_SEED = 32'h0000_0001
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   start_i,
    dcfifo_write_control_if.master fifo_wr,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [8:0]             word_count_o
);

`ifdef DCFIFO_WRCTL_LFSR_EN
    // An all-zero LFSR state would lock up, so a zero seed is substituted.
    localparam logic [31:0] SEED_EFF = (DATA_SEED == 32'h0000_0000) ? 32'h0000_0001 : DATA_SEED;
`else
    localparam logic [31:0] SEED_EFF = DATA_SEED;
`endif

    localparam logic [8:0] LAST_COUNT = 9'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [8:0]  count_q, count_d;
    logic        accept;

    function automatic logic [31:0] next_word(input logic [31:0] d);
`ifdef DCFIFO_WRCTL_LFSR_EN
        return {d[30:0], d[31] ^ d[21] ^ d[1] ^ d[0]};
`else
        return d + 32'd1;
`endif
    endfunction

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_q  <= SEED_EFF;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = WRITE;
                    data_d  = SEED_EFF;
                    count_d = '0;
                end
            end
            WRITE: begin
                // A full FIFO freezes data and count so the stalled word is re-presented on resume.
                accept = !fifo_wr.wrfull_i;
                if (accept) begin
                    data_d  = next_word(data_q);
                    count_d = count_q + 9'd1;
                    if (count_d == LAST_COUNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                data_d  = SEED_EFF;
                count_d = '0;
            end
        endcase
    end

    assign fifo_wr.wrreq_o = accept;
    assign fifo_wr.data_o  = data_q;
    assign word_count_o    = count_q;
    assign busy_o          = (state_q == WRITE) || (state_q == DONE);
    assign done_o          = (state_q == DONE);

    a_no_write_when_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(fifo_wr.wrreq_o && fifo_wr.wrfull_i));

    a_count_in_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        word_count_o <= LAST_COUNT);

endmodule

// File: tb/tb_dcfifo_write_control.sv
// Bench for dcfifo_write_control: directed vector tables, stall/reset sequences and randomized traffic
// checked against a transaction-level reference (word k of a burst is pattern(seed, k)).
module tb_dcfifo_write_control;

    localparam int NI = 5;
    localparam int unsigned LENS [NI] = '{4, 8, 4, 256, 3};
    localparam logic [31:0] SEEDS [NI] = '{32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFE,
                                           32'h0000_0001, 32'h0000_0001};

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NI-1:0] start = '0;
    logic [NI-1:0] full  = '0;
    logic [NI-1:0] wrreq;
    logic [NI-1:0] busy;
    logic [NI-1:0] done;
    logic [31:0]   data  [NI];
    logic [8:0]    count [NI];

    int checks = 0;
    int errors = 0;

    // Reference state: burst in progress, done pulse pending, words accepted so far.
    bit m_burst [NI];
    bit m_done  [NI];
    int m_count [NI];

    typedef struct {
        int          sel;
        bit          st;
        bit          fl;
        bit          wrreq;
        logic [31:0] data;
        bit          busy;
        bit          done;
        logic [8:0]  count;
    } vec_t;

    vec_t tbl [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dcfifo_write_control_if u_if ();

        assign u_if.wrfull_i = full[g];
        assign wrreq[g]      = u_if.wrreq_o;
        assign data[g]       = u_if.data_o;

        dcfifo_write_control #(
            .BURST_LEN (LENS[g]),
            .DATA_SEED (SEEDS[g])
        ) u_dut (
            .clk_i        (clk),
            .reset_n_i    (rst_n),
            .start_i      (start[g]),
            .fifo_wr      (u_if.master),
            .busy_o       (busy[g]),
            .done_o       (done[g]),
            .word_count_o (count[g])
        );
    end

    function automatic logic [31:0] pattern(input logic [31:0] seed, input int k);
`ifdef DCFIFO_WRCTL_LFSR_EN
        logic [31:0] d;
        d = (seed == 32'h0) ? 32'h1 : seed;
        for (int i = 0; i < k; i++) d = {d[30:0], d[31] ^ d[21] ^ d[1] ^ d[0]};
        return d;
`else
        return seed + 32'(k);
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [NI-1:0] st, input logic [NI-1:0] fl);
        @(negedge clk);
        start = st;
        full  = fl;
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_burst[i] = 1'b0;
            m_done[i]  = 1'b0;
            m_count[i] = 0;
        end
    endtask

    // Compare every instance against the reference, then apply the coming clock edge to the reference.
    task automatic check_and_advance();
        logic [63:0] exp_v, act_v;
        for (int i = 0; i < NI; i++) begin
            exp_v = {20'b0, (m_burst[i] && !full[i]), (m_burst[i] || m_done[i]), m_done[i],
                     9'(m_count[i]), pattern(SEEDS[i], m_count[i])};
            act_v = {20'b0, wrreq[i], busy[i], done[i], count[i], data[i]};
            chk($sformatf("model_u%0d{wrreq,busy,done,count,data}", i), act_v, exp_v);
        end
        for (int i = 0; i < NI; i++) begin
            if (m_done[i]) begin
                m_done[i] = 1'b0;
            end else if (m_burst[i]) begin
                if (!full[i]) begin
                    m_count[i]++;
                    if (m_count[i] == int'(LENS[i])) begin
                        m_burst[i] = 1'b0;
                        m_done[i]  = 1'b1;
                    end
                end
            end else if (start[i]) begin
                m_burst[i] = 1'b1;
                m_count[i] = 0;
            end
        end
    endtask

    task automatic pulse_reset(input int hold_cycles);
        @(negedge clk);
        rst_n = 1'b0;
        start = '0;
        full  = '0;
        model_reset();
        #1;
        check_and_advance();
        repeat (hold_cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic void add(input int sel, input bit st, input bit fl, input bit wr,
                                input logic [31:0] d, input bit b, input bit dn, input logic [8:0] c);
        vec_t v;
        v.sel = sel; v.st = st; v.fl = fl; v.wrreq = wr;
        v.data = d; v.busy = b; v.done = dn; v.count = c;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [NI-1:0] st_r, fl_r;
        logic [63:0]   exp_v, act_v;
        logic [31:0]   l1, l2, l3;

`ifdef DCFIFO_WRCTL_LFSR_EN
        l1 = 32'h0000_0003; l2 = 32'h0000_0006; l3 = 32'h0000_000D;
`else
        l1 = 32'h0000_0002; l2 = 32'h0000_0003; l3 = 32'h0000_0004;
`endif

        // sel, start, full | wrreq, data, busy, done, count
        add(0, 1, 0, 0, 32'h1, 0, 0, 9'd0);
        add(0, 0, 0, 1, 32'h1, 1, 0, 9'd0);
        add(0, 0, 0, 1, 32'h2, 1, 0, 9'd1);
        add(0, 0, 0, 1, 32'h3, 1, 0, 9'd2);
        add(0, 0, 0, 1, 32'h4, 1, 0, 9'd3);
        add(0, 1, 0, 0, 32'h5, 1, 1, 9'd4);
        add(0, 0, 0, 0, 32'h5, 0, 0, 9'd4);
        add(2, 1, 0, 0, 32'hFFFF_FFFE, 0, 0, 9'd0);
        add(2, 0, 0, 1, 32'hFFFF_FFFE, 1, 0, 9'd0);
        add(2, 0, 0, 1, 32'hFFFF_FFFF, 1, 0, 9'd1);
        add(2, 0, 0, 1, 32'h0000_0000, 1, 0, 9'd2);
        add(2, 0, 0, 1, 32'h0000_0001, 1, 0, 9'd3);
        add(2, 0, 0, 0, 32'h0000_0002, 1, 1, 9'd4);
        add(2, 0, 0, 0, 32'h0000_0002, 0, 0, 9'd4);
        add(4, 1, 0, 0, 32'h1, 0, 0, 9'd0);
        add(4, 0, 0, 1, 32'h1, 1, 0, 9'd0);
        add(4, 0, 0, 1, l1,    1, 0, 9'd1);
        add(4, 0, 0, 1, l2,    1, 0, 9'd2);
        add(4, 0, 0, 0, l3,    1, 1, 9'd3);
        add(4, 0, 0, 0, l3,    0, 0, 9'd3);

        model_reset();
        pulse_reset(3);

        // Idle after reset: no writes for 100 cycles.
        for (int c = 0; c < 100; c++) begin
            drive('0, '0);
            chk("idle_wrreq", 64'(wrreq), 64'd0);
            check_and_advance();
        end

        foreach (tbl[r]) begin
            drive(NI'(tbl[r].st) << tbl[r].sel, NI'(tbl[r].fl) << tbl[r].sel);
            exp_v = {20'b0, tbl[r].wrreq, tbl[r].busy, tbl[r].done, tbl[r].count, tbl[r].data};
            act_v = {20'b0, wrreq[tbl[r].sel], busy[tbl[r].sel], done[tbl[r].sel],
                     count[tbl[r].sel], data[tbl[r].sel]};
            chk($sformatf("vec%0d{wrreq,busy,done,count,data}", r), act_v, exp_v);
            check_and_advance();
        end

        // Stall: FIFO full for 5 cycles after the third write of an 8-word burst.
        drive(NI'(2), '0);
        check_and_advance();
        for (int k = 0; k < 3; k++) begin
            drive('0, '0);
            check_and_advance();
        end
        for (int k = 0; k < 5; k++) begin
            drive('0, NI'(2));
            chk("stall_wrreq", 64'(wrreq[1]), 64'd0);
            chk("stall_data", 64'(data[1]), 64'd4);
            check_and_advance();
        end
        for (int k = 0; k < 5; k++) begin
            drive('0, '0);
            chk("resume_data", 64'(data[1]), 64'(4 + k));
            chk("resume_wrreq", 64'(wrreq[1]), 64'd1);
            check_and_advance();
        end
        drive('0, '0);
        chk("stall_done", 64'(done[1]), 64'd1);
        chk("stall_count", 64'(count[1]), 64'd8);
        check_and_advance();

        // Reset after 10 of 256 writes abandons the burst.
        drive(NI'(8), '0);
        check_and_advance();
        for (int k = 0; k < 10; k++) begin
            drive('0, '0);
            check_and_advance();
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {20'b0, wrreq[3], busy[3], done[3], count[3], data[3]},
            {20'b0, 1'b0, 1'b0, 1'b0, 9'd0, 32'h1});
        model_reset();
        check_and_advance();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive('0, '0);
            chk("post_rst_quiet", {62'b0, wrreq[3], done[3]}, 64'd0);
            check_and_advance();
        end
        drive(NI'(8), '0);
        check_and_advance();
        for (int k = 0; k < 256; k++) begin
            drive('0, '0);
            if (k == 0 || k == 255) chk("full_burst_data", 64'(data[3]), 64'(k + 1));
            check_and_advance();
        end
        drive('0, '0);
        chk("full_burst_done", 64'(done[3]), 64'd1);
        chk("full_burst_count", 64'(count[3]), 64'd256);
        check_and_advance();

        // Randomized start/full traffic on the short-burst instances.
        for (int c = 0; c < 600; c++) begin
            st_r = '0;
            fl_r = '0;
            for (int i = 0; i < NI; i++) begin
                if (i != 3) begin
                    st_r[i] = ($urandom_range(0, 3) == 0);
                    fl_r[i] = ($urandom_range(0, 2) == 0);
                end
            end
            drive(st_r, fl_r);
            check_and_advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
